// File: rtl/ysyx_25040105_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ysyx_25040105_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    // addi x0,x0,0 : harmless filler handed to decode when a fetch faults
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    // Instruction fetches are always word aligned; the low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040105_ifu_pc.sv
// PC register with next-PC selection (hold / +4 / aligned redirect) and the
// misaligned-redirect flag that travels with the PC until its instruction retires.
module ysyx_25040105_ifu_pc
    import ysyx_25040105_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc,
    output logic        misalign
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        misalign_reg;
    logic        misalign_next;

    // Redirect wins over sequential advance; otherwise the PC holds.
    always_comb begin
        pc_next       = pc_reg;
        misalign_next = misalign_reg;
        if (redirect_valid) begin
            pc_next       = align_word(redirect_pc);
            misalign_next = |redirect_pc[1:0];
        end else if (advance) begin
            pc_next       = pc_reg + 32'd4;
            misalign_next = 1'b0;
        end
    end

    // PC and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

    assign pc       = pc_reg;
    assign misalign = misalign_reg;

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: one outstanding imem request, sequential PC,
// redirects from execute, and a held {inst, inst_pc, fault} for decode.
module ysyx_25040105_ifu
    import ysyx_25040105_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_fault
);

    ifu_state_e        state_reg;
    ifu_state_e        state_next;
    logic              drop_reg;
    logic              drop_next;
    logic              req_valid_reg;
    logic [INST_W-1:0] inst_reg;
    logic [31:0]       inst_pc_reg;
    logic              fault_reg;
    logic              latch_rsp;
    logic              advance;
    logic              req_fire;
    logic [31:0]       pc;
    logic              misalign;

    ysyx_25040105_ifu_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (advance),
        .pc            (pc),
        .misalign      (misalign)
    );

    // req_valid_reg is only ever high in REQ, so it alone qualifies the handshake.
    assign req_fire = req_valid_reg & imem_req_ready;
    // A consume that coincides with a redirect retires the old inst but the PC takes the target.
    assign advance  = (state_reg == IFU_HOLD) & inst_ready & ~redirect_valid;

    // Next-state and drop-flag decisions; redirect outranks every other event.
    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        latch_rsp  = 1'b0;
        case (state_reg)
            IFU_REQ: begin
                if (req_fire) begin
                    state_next = IFU_WAIT;
                    // a request accepted alongside a redirect fetches the old PC
                    drop_next  = redirect_valid;
                end
            end
            IFU_WAIT: begin
                if (imem_rsp_valid) begin
                    // the outstanding fetch has completed; a stale one is simply thrown away
                    if (redirect_valid || drop_reg) begin
                        state_next = IFU_REQ;
                        drop_next  = 1'b0;
                    end else begin
                        state_next = IFU_HOLD;
                        latch_rsp  = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_next = IFU_REQ;
                end
            end
            default: begin
                state_next = IFU_REQ;
                drop_next  = 1'b0;
            end
        endcase
    end

    // State, drop flag and registered request/instruction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IFU_REQ;
            drop_reg      <= 1'b0;
            req_valid_reg <= 1'b0;
            inst_reg      <= '0;
            inst_pc_reg   <= '0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drop_reg      <= drop_next;
            req_valid_reg <= (state_next == IFU_REQ);
            if (latch_rsp) begin
                inst_reg    <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                inst_pc_reg <= pc;
                fault_reg   <= imem_rsp_err | misalign;
            end
        end
    end

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_reg == IFU_HOLD);
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
    assign fetch_fault    = fault_reg;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Bench for the fetch unit: an imem model with programmable latency and an
// architectural PC-stream model checked against every presented instruction.
module tb_ysyx_25040105_ifu;
    import ysyx_25040105_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ysyx_25040105_ifu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // imem model: content is a hash of the address, faults come from a table
    bit          err_en = 1'b0;
    bit          err_tab [64];
    int          lat_knob = 1;
    int          mq_left[$];
    logic [31:0] mq_addr[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return err_en && err_tab[a[7:2]];
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return mem_err(a) ? 32'h0000_0013 : mem_data(a);
    endfunction

    // architectural model: PC of the next instruction to retire and its pending misalign flag
    logic [31:0] mpc  = 32'h8000_0000;
    logic        mmis = 1'b0;

    int          cyc = 0;
    int          idle = 0;
    bit          hs_flag;
    logic [31:0] last_req_addr;
    int          cons_cyc[$];
    logic [31:0] cons_pc[$];

    // One clock: sample outputs at negedge, check, then drive inputs for the next posedge.
    task automatic cycle(input logic rq_rdy, input logic in_rdy, input logic rd_v, input logic [31:0] rd_pc);
        logic hs;
        logic cons;
        @(negedge clk);
        cyc++;
        if (inst_valid) begin
            check("inst_pc", inst_pc, mpc);
            check("inst", inst, exp_inst(mpc));
            check("fault", {31'b0, fetch_fault}, {31'b0, mem_err(mpc) | mmis});
            idle = 0;
        end else begin
            idle++;
        end
        if (idle > 150) begin
            check("progress", 32'(idle), 32'd0);
            idle = 0;
        end
        check("single_outstanding",
              {31'b0, imem_req_valid & ((mq_left.size() != 0) | inst_valid)}, 32'd0);

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
        if (mq_left.size() != 0) begin
            if (mq_left[0] == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(mq_addr[0]);
                imem_rsp_err   = mem_err(mq_addr[0]);
                void'(mq_left.pop_front());
                void'(mq_addr.pop_front());
            end else begin
                mq_left[0] = mq_left[0] - 1;
            end
        end

        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        redirect_valid = rd_v;
        redirect_pc    = rd_pc;

        hs = imem_req_valid & rq_rdy;
        if (hs) begin
            check("req_addr", imem_req_addr, mpc);
            mq_left.push_back(lat_knob - 1);
            mq_addr.push_back(imem_req_addr);
            last_req_addr = imem_req_addr;
            hs_flag = 1'b1;
        end

        cons = inst_valid & in_rdy;
        if (cons) begin
            $display("consume cyc=%0d pc=%h inst=%h fault=%b", cyc, inst_pc, inst, fetch_fault);
            cons_cyc.push_back(cyc);
            cons_pc.push_back(inst_pc);
        end
        if (rd_v) begin
            mpc  = {rd_pc[31:2], 2'b00};
            mmis = (rd_pc[1:0] != 2'b00);
        end else if (cons) begin
            mpc  = mpc + 32'd4;
            mmis = 1'b0;
        end
    endtask

    task automatic run_until_req();
        hs_flag = 1'b0;
        for (int i = 0; i < 30 && !hs_flag; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("req_seen", {31'b0, hs_flag}, 32'd1);
    endtask

    task automatic run_until_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'd0);
            seen = inst_valid;
        end
        check("valid_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic apply_reset_model();
        mq_left.delete();
        mq_addr.delete();
        imem_rsp_valid = 1'b0;
        mpc  = 32'h8000_0000;
        mmis = 1'b0;
    endtask

    initial begin
        logic [31:0] bp_pc;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 64; i++) err_tab[i] = 1'b0;

        // power-on reset values
        #12;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h8000_0000);

        // sequential fetch, 1-cycle memory, decode always ready
        lat_knob = 1;
        cons_cyc.delete();
        cons_pc.delete();
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        if (cons_pc.size() >= 3) begin
            check("seq_pc0", cons_pc[0], 32'h8000_0000);
            check("seq_pc1", cons_pc[1], 32'h8000_0004);
            check("seq_pc2", cons_pc[2], 32'h8000_0008);
            check("seq_gap1", 32'(cons_cyc[1] - cons_cyc[0]), 32'd3);
            check("seq_gap2", 32'(cons_cyc[2] - cons_cyc[1]), 32'd3);
        end else begin
            check("seq_count", 32'(cons_pc.size()), 32'd3);
        end

        // backpressure: instruction held for 5 cycles, no new request
        run_until_valid();
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("bp_inst_pc", inst_pc, mpc);
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        bp_pc = mpc;
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        run_until_req();
        check("bp_next_addr", last_req_addr, bp_pc + 32'd4);

        // redirect while waiting: the in-flight response is discarded
        lat_knob = 3;
        run_until_req();
        cycle(1'b0, 1'b1, 1'b1, 32'h8000_0100);
        lat_knob = 1;
        run_until_req();
        check("redir_wait_addr", last_req_addr, 32'h8000_0100);
        run_until_valid();
        check("redir_wait_pc", inst_pc, 32'h8000_0100);

        // misaligned redirect from HOLD
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0102);
        run_until_valid();
        check("mis_addr", last_req_addr, 32'h8000_0100);
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        run_until_valid();
        check("mis_next_fault", {31'b0, fetch_fault}, 32'd0);
        check("mis_next_pc", inst_pc, 32'h8000_0104);

        // access fault turns into a NOP with fetch_fault
        err_en = 1'b1;
        err_tab[0] = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0200);
        run_until_valid();
        check("err_inst", inst, 32'h0000_0013);
        check("err_fault", {31'b0, fetch_fault}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        err_en = 1'b0;
        err_tab[0] = 1'b0;

        // PC wraps from the top of the address space
        run_until_valid();
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run_until_valid();
        check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        run_until_req();
        check("wrap_addr", last_req_addr, 32'h0000_0000);

        // asynchronous reset in the middle of WAIT
        lat_knob = 3;
        run_until_req();
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("mid_rst_addr", imem_req_addr, 32'h8000_0000);
        check("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_inst_pc", inst_pc, 32'd0);
        apply_reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check("mid_post_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("mid_post_addr", imem_req_addr, 32'h8000_0000);

        // randomized traffic against the model
        err_en = 1'b1;
        for (int i = 0; i < 64; i++) err_tab[i] = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            lat_knob = $urandom_range(1, 3);
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : {20'h80000, 12'($urandom)};
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
